// File: rtl/mult_host_ctrl.sv
// Requester-side controller for the shift-add multiplier: queues operand pairs,
// issues them one at a time, collects the product and hands it downstream.
module mult_host_ctrl #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 40
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               mul_valid_data,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic               mul_done,
  input  logic [2*WIDTH-1:0] mul_product,
  output logic               mul_ack,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*WIDTH-1:0] res_product,
  output logic               res_timeout,
  output logic               busy
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned WDW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]    L_DEPTH = (AW + 1)'(DEPTH);
  localparam logic [WDW-1:0] L_TLAST = WDW'(TIMEOUT - 1);
  localparam logic [WDW-1:0] L_TSAT  = WDW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_ACK,
    S_RESP
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_mem_a [DEPTH];
  logic [WIDTH-1:0] r_mem_b [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic [WDW-1:0]   r_wd;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_timeout;

  assign in_ready       = (r_count < L_DEPTH);
  assign w_empty        = (r_count == '0);
  assign w_push         = in_valid && in_ready;
  assign w_timeout      = (r_wd == L_TLAST);
  assign mul_valid_data = (r_state == S_REQ);
  assign mul_ack        = (r_state == S_ACK) || ((r_state == S_IDLE) && mul_done);
  assign res_valid      = (r_state == S_RESP);
  assign busy           = (r_state != S_IDLE) || !w_empty;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A stale done left by an aborted request is acked before anything is popped.
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!mul_done && !w_empty) begin
          w_pop  = 1'b1;
          w_next = S_REQ;
        end
      end
      S_REQ: begin
        if (mul_done) begin
          w_next = S_ACK;
        end else if (w_timeout) begin
          w_next = S_RESP;
        end
      end
      S_ACK:   w_next = S_RESP;
      S_RESP: begin
        if (res_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (w_push) begin
      r_mem_a[r_wptr] <= in_a;
      r_mem_b[r_wptr] <= in_b;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      mul_a       <= '0;
      mul_b       <= '0;
      res_product <= '0;
      res_timeout <= 1'b0;
      r_wd        <= '0;
    end else begin
      if (w_pop) begin
        mul_a <= r_mem_a[r_rptr];
        mul_b <= r_mem_b[r_rptr];
        r_wd  <= '0;
      end
      if (r_state == S_REQ) begin
        if (r_wd != L_TSAT) begin
          r_wd <= r_wd + 1'b1;
        end
        if (mul_done) begin
          res_product <= mul_product;
          res_timeout <= 1'b0;
        end else if (w_timeout) begin
          res_product <= '0;
          res_timeout <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_host_ctrl.sv
// Directed self-checking bench for mult_host_ctrl with a behavioural multiplier.
module tb_mult_host_ctrl;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        mul_valid_data;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_ack;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [63:0] res_product;
  logic        res_timeout;
  logic        busy;

  logic        m_done = 1'b0;
  logic [63:0] m_prod = '0;
  int          m_cnt = 0;
  int          m_delay = 34;
  bit          m_stuck = 1'b0;
  bit          m_inject = 1'b0;

  int errors = 0;
  int checks = 0;
  int ack_cnt = 0;

  always #5 Clock = ~Clock;

  mult_host_ctrl #(.WIDTH(32), .DEPTH(4), .TIMEOUT(40)) dut (
    .Clock(Clock), .Reset(Reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_valid_data(mul_valid_data), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(m_done), .mul_product(m_prod), .mul_ack(mul_ack),
    .res_valid(res_valid), .res_ready(res_ready), .res_product(res_product),
    .res_timeout(res_timeout), .busy(busy)
  );

  // Multiplier model: raises done m_delay cycles into a request, holds it until ack.
  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      m_done <= 1'b0;
      m_cnt  <= 0;
    end else if (m_inject) begin
      m_done <= 1'b1;
      m_prod <= 64'hDEAD_BEEF;
    end else if (m_done) begin
      if (mul_ack) m_done <= 1'b0;
    end else if (!mul_valid_data) begin
      m_cnt <= 0;
    end else if (!m_stuck) begin
      if (m_cnt >= m_delay - 1) begin
        m_done <= 1'b1;
        m_prod <= {32'b0, mul_a} * {32'b0, mul_b};
        m_cnt  <= 0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  always @(posedge Clock) begin
    if (!Reset && mul_ack) ack_cnt <= ack_cnt + 1;
  end

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    int g = 0;
    while (!in_ready && g < 200) begin
      @(negedge Clock);
      g++;
    end
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    @(negedge Clock);
    in_valid = 1'b0;
  endtask

  task automatic wait_res(input int maxc, output bit ok, output int cyc);
    ok = 1'b0;
    cyc = 0;
    while (!ok && cyc < maxc) begin
      if (res_valid) ok = 1'b1;
      else begin
        @(negedge Clock);
        cyc++;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge Clock);
    checks++; if (mul_valid_data !== 1'b0) begin errors++; $display("FAIL reset_mul_valid_data got=%b want=0", mul_valid_data); end
    checks++; if (mul_ack !== 1'b0) begin errors++; $display("FAIL reset_mul_ack got=%b want=0", mul_ack); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got=%b want=0", res_valid); end
    checks++; if (res_timeout !== 1'b0) begin errors++; $display("FAIL reset_res_timeout got=%b want=0", res_timeout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (mul_a !== 32'd0 || mul_b !== 32'd0) begin errors++; $display("FAIL reset_operands got=%h/%h want=0/0", mul_a, mul_b); end
    checks++; if (res_product !== 64'd0) begin errors++; $display("FAIL reset_res_product got=%h want=0", res_product); end
    Reset = 1'b0;
    @(negedge Clock);
  endtask

  task automatic test_single();
    int a0, cyc;
    bit ok;
    m_delay = 34;
    res_ready = 1'b0;
    a0 = ack_cnt;
    push(32'd3, 32'd5);
    checks++; if (mul_valid_data !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_accept_cycle got=valid%b/busy%b want=valid0/busy1", mul_valid_data, busy); end
    @(negedge Clock);
    checks++; if (mul_valid_data !== 1'b1) begin errors++; $display("FAIL single_issue_latency got=%b want=1", mul_valid_data); end
    checks++; if (mul_a !== 32'd3 || mul_b !== 32'd5) begin errors++; $display("FAIL single_operands got=%0d/%0d want=3/5", mul_a, mul_b); end
    wait_res(100, ok, cyc);
    checks++; if (!ok) begin errors++; $display("FAIL single_res_wait got=no_result want=res_valid"); end
    checks++; if (cyc !== 36) begin errors++; $display("FAIL single_res_latency got=%0d want=36", cyc); end
    checks++; if (res_product !== 64'd15 || res_timeout !== 1'b0) begin errors++; $display("FAIL single_product got=%0d/to%b want=15/to0", res_product, res_timeout); end
    checks++; if (ack_cnt - a0 !== 1) begin errors++; $display("FAIL single_ack_pulses got=%0d want=1", ack_cnt - a0); end
    res_ready = 1'b1;
    @(negedge Clock);
    res_ready = 1'b0;
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_release got=valid%b/busy%b want=valid0/busy0", res_valid, busy); end
  endtask

  task automatic test_fifo_fill();
    int exp_p[5] = '{2, 12, 30, 56, 90};
    int cyc;
    bit ok;
    m_delay = 3;
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(32'(2 * i + 1), 32'(2 * i + 2));
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready_full got=%b want=0", in_ready); end
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_res(100, ok, cyc);
      checks++; if (!ok || res_product !== 64'(exp_p[i])) begin errors++; $display("FAIL fill_result_%0d got=%0d ok=%b want=%0d", i, res_product, ok, exp_p[i]); end
      @(negedge Clock);
    end
    res_ready = 1'b0;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL fill_drained got=busy%b/rdy%b want=busy0/rdy1", busy, in_ready); end
  endtask

  task automatic test_backpressure();
    int cyc;
    bit ok;
    m_delay = 3;
    res_ready = 1'b0;
    push(32'd2, 32'd7);
    push(32'd4, 32'd4);
    wait_res(100, ok, cyc);
    checks++; if (!ok || res_product !== 64'd14) begin errors++; $display("FAIL bp_first got=%0d ok=%b want=14", res_product, ok); end
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      checks++;
      if (res_valid !== 1'b1 || res_product !== 64'd14 || mul_valid_data !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d got=valid%b/prod%0d/req%b want=valid1/prod14/req0", i, res_valid, res_product, mul_valid_data);
      end
    end
    res_ready = 1'b1;
    @(negedge Clock);
    res_ready = 1'b0;
    checks++; if (mul_valid_data !== 1'b0 || res_valid !== 1'b0) begin errors++; $display("FAIL bp_idle_gap got=req%b/valid%b want=req0/valid0", mul_valid_data, res_valid); end
    @(negedge Clock);
    checks++; if (mul_valid_data !== 1'b1 || mul_a !== 32'd4) begin errors++; $display("FAIL bp_next_issue got=req%b/a%0d want=req1/a4", mul_valid_data, mul_a); end
    wait_res(100, ok, cyc);
    checks++; if (!ok || res_product !== 64'd16) begin errors++; $display("FAIL bp_second got=%0d ok=%b want=16", res_product, ok); end
    res_ready = 1'b1;
    @(negedge Clock);
    res_ready = 1'b0;
  endtask

  task automatic test_watchdog_stale();
    int a0, k, cyc;
    bit ok;
    m_stuck = 1'b1;
    m_delay = 3;
    res_ready = 1'b0;
    a0 = ack_cnt;
    push(32'd6, 32'd7);
    @(negedge Clock);
    k = 0;
    while (!res_valid && k < 100) begin
      @(negedge Clock);
      k++;
    end
    checks++; if (k !== 40) begin errors++; $display("FAIL wd_latency got=%0d want=40", k); end
    checks++; if (res_product !== 64'd0 || res_timeout !== 1'b1) begin errors++; $display("FAIL wd_result got=%0d/to%b want=0/to1", res_product, res_timeout); end
    checks++; if (ack_cnt - a0 !== 0) begin errors++; $display("FAIL wd_no_ack got=%0d want=0", ack_cnt - a0); end
    push(32'd11, 32'd3);
    checks++; if (mul_valid_data !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL stale_queued got=req%b/busy%b want=req0/busy1", mul_valid_data, busy); end
    m_stuck = 1'b0;
    m_inject = 1'b1;
    res_ready = 1'b1;
    @(negedge Clock);
    m_inject = 1'b0;
    res_ready = 1'b0;
    checks++; if (mul_ack !== 1'b1 || mul_valid_data !== 1'b0) begin errors++; $display("FAIL stale_ack got=ack%b/req%b want=ack1/req0", mul_ack, mul_valid_data); end
    @(negedge Clock);
    checks++; if (mul_ack !== 1'b0 || mul_valid_data !== 1'b0) begin errors++; $display("FAIL stale_after_ack got=ack%b/req%b want=ack0/req0", mul_ack, mul_valid_data); end
    @(negedge Clock);
    checks++; if (mul_valid_data !== 1'b1 || mul_a !== 32'd11 || mul_b !== 32'd3) begin errors++; $display("FAIL stale_issue got=req%b/%0d/%0d want=req1/11/3", mul_valid_data, mul_a, mul_b); end
    wait_res(100, ok, cyc);
    checks++; if (!ok || res_product !== 64'd33 || res_timeout !== 1'b0) begin errors++; $display("FAIL stale_result got=%0d/to%b ok=%b want=33/to0", res_product, res_timeout, ok); end
    checks++; if (ack_cnt - a0 !== 2) begin errors++; $display("FAIL stale_ack_total got=%0d want=2", ack_cnt - a0); end
    res_ready = 1'b1;
    @(negedge Clock);
    res_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int a0;
    m_delay = 34;
    res_ready = 1'b0;
    push(32'd9, 32'd9);
    push(32'd2, 32'd2);
    repeat (9) @(negedge Clock);
    checks++; if (mul_valid_data !== 1'b1) begin errors++; $display("FAIL rst_mid_in_req got=%b want=1", mul_valid_data); end
    a0 = ack_cnt;
    #2 Reset = 1'b1;
    #1;
    checks++; if (mul_valid_data !== 1'b0 || res_valid !== 1'b0 || mul_ack !== 1'b0) begin errors++; $display("FAIL rst_mid_outputs got=req%b/valid%b/ack%b want=0/0/0", mul_valid_data, res_valid, mul_ack); end
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_fifo got=rdy%b/busy%b want=rdy1/busy0", in_ready, busy); end
    checks++; if (mul_a !== 32'd0 || res_product !== 64'd0) begin errors++; $display("FAIL rst_mid_regs got=%0d/%0d want=0/0", mul_a, res_product); end
    @(negedge Clock);
    Reset = 1'b0;
    repeat (5) @(negedge Clock);
    checks++; if (mul_valid_data !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_empty got=req%b/busy%b want=req0/busy0", mul_valid_data, busy); end
    checks++; if (ack_cnt - a0 !== 0) begin errors++; $display("FAIL rst_mid_no_ack got=%0d want=0", ack_cnt - a0); end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    test_reset();
    test_single();
    test_fifo_fill();
    test_backpressure();
    test_watchdog_stale();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
